// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the nibble CPU.
// Owns the PC, addresses the combinational instruction ROM and registers each
// returned byte together with its fetch address into a one-entry output slot
// that the decoder drains over a valid/ready handshake.
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   rom_addr_o     ROM address, equal to the PC register
//   rom_data_i     ROM byte for rom_addr_o, same cycle
//   instr_o        registered instruction byte
//   instr_pc_o     address instr_o was fetched from
//   instr_valid_o  instr_o/instr_pc_o hold an unconsumed byte
//   instr_ready_i  decoder accepts the byte this cycle
//   jump_en_i      redirect fetch to jump_addr_i (one-cycle pulse)
//   jump_addr_i    jump target
//   halt_i         stop fetching after the current cycle
//   halted_o       unit is in HALT state
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              halt_i,
    output logic              halted_o
);
    typedef enum logic {RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              take, slot_free;

    assign take      = valid_q & instr_ready_i;
    assign slot_free = ~valid_q | take;

    // Priority: jump > halt (or already halted) > fetch. rom_data_i only ever
    // feeds instr_d, so x bits in the ROM cannot reach control state.
    always_comb begin
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        state_d = state_q;
        if (jump_en_i) begin
            pc_d    = jump_addr_i;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (state_q == HALT || halt_i) begin
            state_d = HALT;
            valid_d = valid_q & ~take;
        end else if (slot_free) begin
            instr_d = rom_data_i;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= ADDR_W'(RESET_PC);
            ipc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign rom_addr_o    = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus randomized check of instr_fetch_unit against a behavioural model.
module tb_instr_fetch_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rom_addr, instr_pc, jump_addr = '0;
    logic [7:0] rom_data, instr;
    logic       instr_valid, instr_ready = 1'b0, jump_en = 1'b0, halt = 1'b0, halted;
    logic [7:0] rom [32];
    int         vectors = 0, errors = 0;
    int         m_pc, m_ipc;
    logic [7:0] m_instr;
    bit         m_valid, m_halted;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    instr_fetch_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .instr_o(instr), .instr_pc_o(instr_pc), .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .halt_i(halt), .halted_o(halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("instr_valid", instr_valid, m_valid);
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        check("rom_addr", rom_addr, m_pc);
        check("halted", halted, m_halted);
    endtask

    task automatic model_reset();
        m_pc = 0; m_ipc = 0; m_instr = 8'h00; m_valid = 0; m_halted = 0;
    endtask

    // One clock: apply inputs, advance the model by the behavioural rules, compare after the edge.
    task automatic step(input bit rdy, input bit jmp, input int ja, input bit hlt);
        bit take;
        instr_ready = rdy; jump_en = jmp; jump_addr = 5'(ja); halt = hlt;
        #1 check("rom_addr_pre", rom_addr, m_pc);
        take = m_valid && rdy;
        if (jmp) begin
            m_pc = ja; m_valid = 0; m_halted = 0;
        end else if (m_halted || hlt) begin
            m_halted = 1;
            if (take) m_valid = 0;
        end else if (!m_valid || take) begin
            m_instr = rom[m_pc]; m_ipc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % 32;
        end
        @(posedge clk);
        #1 check_all();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h35; rom[1] = 8'h00; rom[2] = 8'h34; rom[3] = 8'h01;
        rom[12] = 8'bxxxx_0101; rom[20] = 8'b1010_xxxx;
        model_reset();
        #12 check_all();
        @(negedge clk) rst_n = 1'b1;
        // Stream 35/0, 00/1, 34/2 then hold 34 under backpressure, then 01/3.
        repeat (3) step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        // Reach byte 5 held, then jump to 9 without consuming it.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 9, 0);
        step(1, 0, 0, 0);
        // Wrap-around from 30.
        step(1, 1, 30, 0);
        repeat (4) step(1, 0, 0, 0);
        // Halt with byte 6 held and no ready, then drain, idle, restart at 0.
        step(0, 1, 6, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (10) step(1, 0, 0, $urandom_range(0, 1));
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // Jump beats halt.
        step(1, 1, 3, 1);
        step(1, 0, 0, 0);
        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk) rst_n = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // Randomized traffic including x-laden ROM bytes.
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 31), $urandom_range(0, 15) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the nibble CPU.
- Owns the program counter and drives the address of the 32x8 combinational instruction ROM.
- Registers each returned byte, with its address, into a one-entry output register.
- Hands bytes to the decoder over a valid/ready handshake. Supports jump redirect, halt and a free-running wrap-around PC.

Parameters:
- ADDR_W, 5, width of PC and ROM address.
- DATA_W, 8, instruction byte width (upper nibble opcode, lower nibble operand).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rom_addr  output  ADDR_W  address to instruction ROM; equals PC register, purely combinational.
- rom_data  input  DATA_W  ROM byte for rom_addr, valid in the same cycle.
- instr  output  DATA_W  registered instruction byte to decoder.
- instr_pc  output  ADDR_W  address the byte in instr was fetched from.
- instr_valid  output  1  instr/instr_pc hold a byte not yet consumed.
- instr_ready  input  1  decoder accepts the byte this cycle.
- jump_en  input  1  redirect fetch to jump_addr; one-cycle pulse.
- jump_addr  input  ADDR_W  jump target.
- halt  input  1  stop fetching after current cycle.
- halted  output  1  unit is in HALT state.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-low (rst_n).
- Reset values (asynchronous, on rst_n low):
  - PC = RESET_PC.
  - instr = 0.
  - instr_pc = 0.
  - instr_valid = 0.
  - state = RUN, halted = 0.
- States: RUN, HALT. halted = (state == HALT).
- Definitions: take = instr_valid & instr_ready; slot_free = ~instr_valid | take.
- Priority per cycle: jump_en > halt > fetch.
- jump_en = 1 (either state):
  - PC <= jump_addr.
  - instr_valid <= 0; flushes any held byte, which counts as consumed if take was also 1.
  - state <= RUN.
  - No fetch this cycle.
  - First post-jump byte (rom byte at jump_addr) is valid one edge later.
- halt = 1, jump_en = 0, state RUN:
  - state <= HALT; no fetch this cycle.
  - Held byte stays offered until taken, then instr_valid <= 0.
  - PC unchanged.
- state HALT, jump_en = 0:
  - No fetch; halt level is ignored.
  - Only jump_en or reset leaves HALT.
- Fetch (RUN, no jump, no halt, slot_free):
  - instr <= rom_data, instr_pc <= PC, instr_valid <= 1.
  - PC <= PC + 1 modulo 2^ADDR_W (31 -> 0 wraps silently).
- Stall (RUN, instr_valid & ~instr_ready): instr, instr_pc, PC all hold. rom_addr stays stable.
- Throughput: with instr_ready held high, one byte per cycle, back-to-back.
- Fetch latency: byte at PC appears on instr one edge after rom_addr = PC.
- Output stability: instr/instr_pc must not change while instr_valid & ~instr_ready.
- rom_data may contain x bits; the byte is passed through unmodified, and no x may reach instr_valid, PC or state.
- Reset asserted mid-stream: all registers return to reset values immediately, with no waiting for a clock edge. The first fetch happens on the first edge after release.

Test Plan:
- Reset release, instr_ready = 1, ROM[0..3] = 35,00,34,01 -> instr_valid rises edge 1; instr/instr_pc = 35/0, 00/1, 34/2, 01/3 on consecutive edges.
- Backpressure: instr_ready = 0 for 3 cycles while instr = 34 (pc 2) -> instr, instr_pc, rom_addr = 3 all stable; on ready, 34 consumed, next byte 01/3.
- Jump: jump_en with jump_addr = 9 while byte at pc 5 held and unconsumed -> instr_valid 0 next edge; following edge instr = ROM[9], instr_pc = 9; byte 5 never accepted.
- Wrap: jump to 30, ready = 1 -> instr_pc sequence 30, 31, 0, 1.
- Halt: halt pulse at pc 6 with held byte and ready = 0 -> halted = 1, byte held; after ready, instr_valid = 0 and stays 0 for 10 cycles. Then jump_en to 0 -> halted = 0, fetch resumes at 0.
- Simultaneous: jump_en and halt both high -> jump wins, halted = 0. Also: rst_n pulsed low mid-stream between edges -> instr_valid = 0, rom_addr = 0 immediately.
